golden_netlist_checker: RTL and testbench

//   Synthesizable result checker downstream of a golden model and its post-route fabric netlist.

---
 rtl/checker_pkg.sv | 11 +
 rtl/golden_align_dly.sv | 26 ++
 rtl/golden_netlist_checker.sv | 140 ++++++++++++++
 tb/tb_golden_netlist_checker.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/checker_pkg.sv
// Shared types and constants for the golden-vs-netlist result checker.
package checker_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_t;

    localparam int unsigned MAX_LAT             = 15;
    localparam int unsigned NUM_EXHAUSTIVE      = 4;
    localparam int unsigned NUM_RANDOM          = 500;
    localparam int unsigned DEFAULT_NUM_VECTORS = NUM_EXHAUSTIVE + NUM_RANDOM;

endpackage

// File: rtl/golden_align_dly.sv
// Fixed-depth shift register carrying golden data plus its valid flag, so the golden stream
// lines up with the slower netlist output. Synchronous active-low clear.
module golden_align_dly #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             clr_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/golden_netlist_checker.sv
// Aligns golden output to netlist latency, compares each qualified sample, counts matches and
// mismatches, captures the first failing vector and reports pass/fail after a fixed vector count.
module golden_netlist_checker
    import checker_pkg::*;
#(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned NUM_VECTORS = DEFAULT_NUM_VECTORS,
    parameter int unsigned NETLIST_LAT = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] golden_in,
    input  logic [WIDTH-1:0] netlist_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_golden,
    output logic [WIDTH-1:0] first_err_netlist
);

    localparam int unsigned LAT   = (NETLIST_LAT > MAX_LAT) ? MAX_LAT : NETLIST_LAT;
    localparam int unsigned IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    chk_state_t       state_q;
    logic             busy_q, done_q, pass_q, err_pulse_q;
    logic [CNT_W-1:0] match_cnt_q, mismatch_cnt_q, first_err_idx_q;
    logic [WIDTH-1:0] first_err_golden_q, first_err_netlist_q;
    logic [IDX_W-1:0] vec_idx_q;

    logic             in_run, al_valid, cmp_valid, cmp_err;
    logic [WIDTH-1:0] al_golden;

    assign in_run = (state_q == RUN);

    generate
        if (LAT == 0) begin : g_bypass
            assign al_valid  = sample_valid;
            assign al_golden = golden_in;
        end else begin : g_dly
            logic           pipe_clr_n;
            logic [WIDTH:0] dly_q;

            // Flush stale samples on every run entry as well as on reset.
            assign pipe_clr_n = rst_n && !(start && !in_run);

            golden_align_dly #(
                .DEPTH (LAT),
                .WIDTH (WIDTH + 1)
            ) u_dly (
                .clk_i  (clk),
                .clr_ni (pipe_clr_n),
                .d_i    ({sample_valid && in_run, golden_in}),
                .q_o    (dly_q)
            );

            assign {al_valid, al_golden} = dly_q;
        end
    endgenerate

    assign cmp_valid = al_valid && in_run;
    // Case inequality so X/Z from the netlist is flagged in simulation.
    assign cmp_err   = (al_golden !== netlist_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            busy_q              <= 1'b0;
            done_q              <= 1'b0;
            pass_q              <= 1'b0;
            err_pulse_q         <= 1'b0;
            match_cnt_q         <= '0;
            mismatch_cnt_q      <= '0;
            first_err_idx_q     <= '0;
            first_err_golden_q  <= '0;
            first_err_netlist_q <= '0;
            vec_idx_q           <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q             <= RUN;
                        busy_q              <= 1'b1;
                        done_q              <= 1'b0;
                        pass_q              <= 1'b0;
                        match_cnt_q         <= '0;
                        mismatch_cnt_q      <= '0;
                        first_err_idx_q     <= '0;
                        first_err_golden_q  <= '0;
                        first_err_netlist_q <= '0;
                        vec_idx_q           <= '0;
                    end
                end
                RUN: begin
                    if (cmp_valid) begin
                        vec_idx_q <= vec_idx_q + 1'b1;
                        if (cmp_err) begin
                            err_pulse_q <= 1'b1;
                            if (mismatch_cnt_q != '1) mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
                            // Saturating count never returns to zero, so zero means no error yet.
                            if (mismatch_cnt_q == '0) begin
                                first_err_idx_q     <= CNT_W'(vec_idx_q);
                                first_err_golden_q  <= al_golden;
                                first_err_netlist_q <= netlist_in;
                            end
                        end else if (match_cnt_q != '1) begin
                            match_cnt_q <= match_cnt_q + 1'b1;
                        end
                        if (vec_idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (mismatch_cnt_q == '0) && !cmp_err;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign pass              = pass_q;
    assign err_pulse         = err_pulse_q;
    assign match_cnt         = match_cnt_q;
    assign mismatch_cnt      = mismatch_cnt_q;
    assign first_err_idx     = first_err_idx_q;
    assign first_err_golden  = first_err_golden_q;
    assign first_err_netlist = first_err_netlist_q;

endmodule

// File: tb/tb_golden_netlist_checker.sv
// Self-checking bench: four checker instances (and2 exhaustive, latency 3, latency 2 vs a
// 3-cycle netlist, 3-bit saturating counters) driven from scenario tasks with scoreboards.
module tb_golden_netlist_checker;

    localparam int unsigned NV = 504;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sample_valid = 1'b0;
    logic gold1 = 1'b0, net1 = 1'b0;
    logic [3:0] gold4 = '0, net4 = '0;
    logic [3:0] gh [4] = '{default: '0};

    logic busy_a, done_a, pass_a, err_a, fg_a, fn_a;
    logic [15:0] mcnt_a, xcnt_a, fidx_a;
    logic busy_b, done_b, pass_b, err_b;
    logic [15:0] mcnt_b, xcnt_b, fidx_b;
    logic [3:0] fg_b, fn_b;
    logic busy_c, done_c, pass_c, err_c;
    logic [15:0] mcnt_c, xcnt_c, fidx_c;
    logic [3:0] fg_c, fn_c;
    logic busy_d, done_d, pass_d, err_d, fg_d, fn_d;
    logic [2:0] mcnt_d, xcnt_d, fidx_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    golden_netlist_checker #(.WIDTH(1), .NUM_VECTORS(4), .NETLIST_LAT(0), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
        .golden_in(gold1), .netlist_in(net1), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_pulse(err_a), .match_cnt(mcnt_a), .mismatch_cnt(xcnt_a), .first_err_idx(fidx_a),
        .first_err_golden(fg_a), .first_err_netlist(fn_a));

    golden_netlist_checker #(.WIDTH(4), .NUM_VECTORS(NV), .NETLIST_LAT(3), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
        .golden_in(gold4), .netlist_in(net4), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_pulse(err_b), .match_cnt(mcnt_b), .mismatch_cnt(xcnt_b), .first_err_idx(fidx_b),
        .first_err_golden(fg_b), .first_err_netlist(fn_b));

    golden_netlist_checker #(.WIDTH(4), .NUM_VECTORS(NV), .NETLIST_LAT(2), .CNT_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
        .golden_in(gold4), .netlist_in(net4), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_pulse(err_c), .match_cnt(mcnt_c), .mismatch_cnt(xcnt_c), .first_err_idx(fidx_c),
        .first_err_golden(fg_c), .first_err_netlist(fn_c));

    golden_netlist_checker #(.WIDTH(1), .NUM_VECTORS(10), .NETLIST_LAT(0), .CNT_W(3)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
        .golden_in(gold1), .netlist_in(net1), .busy(busy_d), .done(done_d), .pass(pass_d),
        .err_pulse(err_d), .match_cnt(mcnt_d), .mismatch_cnt(xcnt_d), .first_err_idx(fidx_d),
        .first_err_golden(fg_d), .first_err_netlist(fn_d));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        sample_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Netlist model for u_b/u_c: net4 is golden from three drives earlier.
    task automatic drive4(input logic [3:0] g);
        for (int i = 3; i > 0; i--) gh[i] = gh[i-1];
        gh[0] = g;
        gold4 = g;
        net4 = gh[3];
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({busy_a, done_a, pass_a, err_a, mcnt_a, xcnt_a, fidx_a, fg_a, fn_a} !== '0) begin
            errors++;
            $display("FAIL reset_a got=%h want=0", {busy_a, done_a, pass_a, err_a, mcnt_a});
        end
        checks++;
        if ({busy_b, done_b, pass_b, err_b, mcnt_b, xcnt_b, fidx_b, fg_b, fn_b} !== '0) begin
            errors++;
            $display("FAIL reset_b got=%h want=0", {busy_b, done_b, pass_b, err_b, mcnt_b});
        end
        checks++;
        if ({busy_d, done_d, pass_d, err_d, mcnt_d, xcnt_d, fidx_d, fg_d, fn_d} !== '0) begin
            errors++;
            $display("FAIL reset_d got=%h want=0", {busy_d, done_d, pass_d, err_d, xcnt_d});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({busy_c, done_c, pass_c, err_c, mcnt_c, xcnt_c} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset_c got=%h want=0", {busy_c, done_c, mcnt_c});
        end
    endtask

    // Exhaustive and2 run on u_a; force_idx >= 0 flips the netlist at that vector.
    task automatic test_and2(input int force_idx);
        logic [1:0] vecs [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
        bit q[$];
        bit e;
        int tot = 0, now = 0, pulses = 0, nerr = 0, exp_idx = 0;
        logic exp_fg = 1'b0, exp_fn = 1'b0;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                sample_valid = 1'b1;
                gold1 = vecs[k][1] & vecs[k][0];
                net1 = (k == force_idx) ? 1'b1 : gold1;
                e = (gold1 !== net1);
                q.push_back(e);
                if (e && nerr == 0) begin
                    exp_idx = k;
                    exp_fg = gold1;
                    exp_fn = net1;
                end
                if (e) nerr++;
            end else begin
                sample_valid = 1'b0;
                net1 = gold1;
            end
            step();
            if (err_a === 1'b1) pulses++;
            now = int'(mcnt_a) + int'(xcnt_a);
            if (now != tot) begin
                tot = now;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL and2_extra_compare got=%0d want=4", now);
                end else begin
                    e = q.pop_front();
                    if (err_a !== e) begin
                        errors++;
                        $display("FAIL and2_err_pulse k=%0d got=%b want=%b", k, err_a, e);
                    end
                end
            end
        end
        checks++;
        if (q.size() != 0 || done_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL and2_done got=%b/%b pending=%0d want=1/0/0", done_a, busy_a, q.size());
        end
        checks++;
        if (int'(mcnt_a) != 4 - nerr || int'(xcnt_a) != nerr) begin
            errors++;
            $display("FAIL and2_counts got=%0d/%0d want=%0d/%0d", mcnt_a, xcnt_a, 4 - nerr, nerr);
        end
        checks++;
        if (pass_a !== (nerr == 0) || pulses != nerr) begin
            errors++;
            $display("FAIL and2_pass got=%b pulses=%0d want=%b/%0d", pass_a, pulses, nerr == 0, nerr);
        end
        checks++;
        if (int'(fidx_a) != exp_idx || fg_a !== exp_fg || fn_a !== exp_fn) begin
            errors++;
            $display("FAIL and2_first_err got=%0d/%b/%b want=%0d/%b/%b",
                     fidx_a, fg_a, fn_a, exp_idx, exp_fg, exp_fn);
        end
    endtask

    // Full 504-vector run against the 3-cycle netlist; optionally scores u_c (LAT=2) as well.
    task automatic run_b(input bit chk_c);
        bit qb[$];
        bit qc[$];
        bit e;
        logic [3:0] g;
        logic [3:0] fg = '0, fn = '0;
        int tot_b = 0, tot_c = 0, now = 0, exp_xc = 0, first_k = -1;
        start = 1'b1;
        drive4(4'h0);
        step();
        start = 1'b0;
        for (int k = 0; k < int'(NV) + 8; k++) begin
            if (k < int'(NV)) begin
                sample_valid = 1'b1;
                g = 4'($urandom);
                drive4(g);
                qb.push_back(1'b0);
                e = (gh[0] != gh[1]);
                qc.push_back(e);
                if (e) begin
                    exp_xc++;
                    if (first_k < 0) begin
                        first_k = k;
                        fg = gh[0];
                        fn = gh[1];
                    end
                end
            end else begin
                sample_valid = 1'b0;
                drive4(4'h0);
            end
            step();
            now = int'(mcnt_b) + int'(xcnt_b);
            if (now != tot_b) begin
                tot_b = now;
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL lat3_extra_compare got=%0d want=%0d", now, NV);
                end else begin
                    e = qb.pop_front();
                    if (err_b !== e) begin
                        errors++;
                        $display("FAIL lat3_err_pulse k=%0d got=%b want=%b", k, err_b, e);
                    end
                end
            end
            checks++;
            if (done_b !== (qb.size() == 0)) begin
                errors++;
                $display("FAIL lat3_done k=%0d got=%b want=%b", k, done_b, qb.size() == 0);
            end
            if (chk_c) begin
                now = int'(mcnt_c) + int'(xcnt_c);
                if (now != tot_c) begin
                    tot_c = now;
                    checks++;
                    if (qc.size() == 0) begin
                        errors++;
                        $display("FAIL lat2_extra_compare got=%0d want=%0d", now, NV);
                    end else begin
                        e = qc.pop_front();
                        if (err_c !== e) begin
                            errors++;
                            $display("FAIL lat2_err_pulse k=%0d got=%b want=%b", k, err_c, e);
                        end
                    end
                end
            end
        end
        checks++;
        if (mcnt_b !== 16'(NV) || xcnt_b !== 16'd0 || pass_b !== 1'b1 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL lat3_final got=%0d/%0d pass=%b busy=%b want=%0d/0/1/0",
                     mcnt_b, xcnt_b, pass_b, busy_b, NV);
        end
        if (chk_c) begin
            checks++;
            if (qc.size() != 0 || int'(xcnt_c) != exp_xc || int'(mcnt_c) != int'(NV) - exp_xc ||
                pass_c !== (exp_xc == 0) || done_c !== 1'b1) begin
                errors++;
                $display("FAIL lat2_final got=%0d/%0d pass=%b done=%b want=%0d/%0d/%b/1",
                         mcnt_c, xcnt_c, pass_c, done_c, int'(NV) - exp_xc, exp_xc, exp_xc == 0);
            end
            checks++;
            if (int'(fidx_c) != ((first_k < 0) ? 0 : first_k) || fg_c !== fg || fn_c !== fn) begin
                errors++;
                $display("FAIL lat2_first_err got=%0d/%h/%h want=%0d/%h/%h",
                         fidx_c, fg_c, fn_c, first_k, fg, fn);
            end
        end
    endtask

    task automatic test_latency();
        do_reset();
        run_b(1'b1);
    endtask

    task automatic test_reset_midrun();
        int guard = 0;
        do_reset();
        start = 1'b1;
        drive4(4'h0);
        step();
        start = 1'b0;
        sample_valid = 1'b1;
        while (int'(mcnt_b) < 100 && guard < 300) begin
            drive4(4'($urandom));
            step();
            guard++;
        end
        checks++;
        if (mcnt_b !== 16'd100) begin
            errors++;
            $display("FAIL midrun_reach got=%0d want=100", mcnt_b);
        end
        rst_n = 1'b0;
        drive4(4'($urandom));
        step();
        checks++;
        if ({busy_b, done_b, pass_b, err_b, mcnt_b, xcnt_b, fidx_b, fg_b, fn_b} !== '0) begin
            errors++;
            $display("FAIL midrun_reset got=%h want=0", {busy_b, done_b, pass_b, err_b, mcnt_b});
        end
        rst_n = 1'b1;
        sample_valid = 1'b0;
        drive4(4'h0);
        step();
        run_b(1'b0);
    endtask

    task automatic test_start_and_idle_valid();
        do_reset();
        sample_valid = 1'b1;
        gold1 = 1'b0;
        net1 = 1'b1;
        repeat (3) step();
        checks++;
        if ({busy_a, err_a, mcnt_a, xcnt_a, fidx_a} !== '0) begin
            errors++;
            $display("FAIL idle_valid got=%0d/%0d busy=%b want=0/0/0", mcnt_a, xcnt_a, busy_a);
        end
        sample_valid = 1'b0;
        net1 = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        sample_valid = 1'b1;
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (mcnt_a !== 16'd3 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL midrun_start got=%0d busy=%b want=3/1", mcnt_a, busy_a);
        end
        step();
        checks++;
        if (mcnt_a !== 16'd4 || done_a !== 1'b1 || pass_a !== 1'b1) begin
            errors++;
            $display("FAIL midrun_start_done got=%0d/%b/%b want=4/1/1", mcnt_a, done_a, pass_a);
        end
        net1 = 1'b1;
        repeat (2) step();
        sample_valid = 1'b0;
        net1 = 1'b0;
        checks++;
        if (mcnt_a !== 16'd4 || xcnt_a !== 16'd0 || err_a !== 1'b0 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL done_valid got=%0d/%0d err=%b done=%b want=4/0/0/1",
                     mcnt_a, xcnt_a, err_a, done_a);
        end
    endtask

    task automatic test_saturation();
        int exp_x;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        gold1 = 1'b0;
        net1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sample_valid = 1'b1;
            step();
            exp_x = (k + 1 > 7) ? 7 : k + 1;
            checks++;
            if (int'(xcnt_d) != exp_x || done_d !== (k == 9) || err_d !== 1'b1) begin
                errors++;
                $display("FAIL saturate k=%0d got=%0d/%b/%b want=%0d/%b/1",
                         k, xcnt_d, done_d, err_d, exp_x, k == 9);
            end
        end
        sample_valid = 1'b0;
        net1 = 1'b0;
        step();
        checks++;
        if (err_d !== 1'b0 || done_d !== 1'b1 || pass_d !== 1'b0 || mcnt_d !== 3'd0 ||
            fidx_d !== 3'd0 || fn_d !== 1'b1) begin
            errors++;
            $display("FAIL saturate_final got=err%b done%b pass%b m%0d idx%0d want=0/1/0/0/0",
                     err_d, done_d, pass_d, mcnt_d, fidx_d);
        end
    endtask

    initial begin
        test_reset();
        test_and2(-1);
        test_and2(2);
        test_latency();
        test_reset_midrun();
        test_start_and_idle_valid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
